// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with whole-line refill in 64-bit beats.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_EN.
module icache #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned LINE_BEATS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_req,
    input  logic [31:0] addr_inst,
    output logic        cache_ready,
    output logic        cache_valid,
    output logic [63:0] inst_i,
    input  logic        fence_i,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic [63:0] perf_hit,
    output logic [63:0] perf_miss
);

    localparam int unsigned OFFSET = 3 + $clog2(LINE_BEATS);
    localparam int unsigned TAG    = 32 - INDEX_BITS - OFFSET;
    localparam int unsigned LINES  = 1 << INDEX_BITS;
    localparam int unsigned BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_REFILL,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [31:3]         addr_q;
    logic [BEAT_W-1:0]   cnt_q;
    logic [63:0]         resp_q;
    logic                fence_pend_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG-1:0]      tag_mem  [LINES];
    logic [63:0]         data_mem [LINES][LINE_BEATS];

    logic [TAG-1:0]        req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [BEAT_W-1:0]     req_beat;
    logic                  hit;
    logic                  last_beat;
    logic                  accept;
    logic [63:0]           lookup_data;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^addr_inst[2:0];

    assign req_tag     = addr_q[31 -: TAG];
    assign req_idx     = addr_q[OFFSET +: INDEX_BITS];
    assign req_beat    = (LINE_BEATS > 1) ? BEAT_W'(addr_q) : '0;
    assign hit         = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign lookup_data = data_mem[req_idx][req_beat];
    assign last_beat   = mem_rvalid && (cnt_q == BEAT_W'(LINE_BEATS - 1));
    assign mem_addr    = {addr_q[31:OFFSET], OFFSET'(0)};

    // Next state and handshake/response outputs
    always_comb begin
        state_d     = state_q;
        cache_ready = 1'b0;
        cache_valid = 1'b0;
        inst_i      = resp_q;
        mem_req     = 1'b0;
        accept      = 1'b0;
        case (state_q)
            S_IDLE: cache_ready = 1'b1;
            S_LOOKUP: begin
                if (hit) begin
                    cache_valid = 1'b1;
                    cache_ready = 1'b1;
                    inst_i      = lookup_data;
                end else begin
                    state_d = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                mem_req = 1'b1;
                if (mem_ready) state_d = S_REFILL;
            end
            S_REFILL: if (last_beat) state_d = S_DONE;
            S_DONE: begin
                cache_valid = 1'b1;
                cache_ready = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (fence_i) cache_ready = 1'b0;
        if (rst) begin
            cache_ready = 1'b0;
            cache_valid = 1'b0;
            mem_req     = 1'b0;
            inst_i      = '0;
        end
        accept = cache_req && cache_ready;
        // Any state that can take a request moves on by the final ready value
        if (state_q == S_IDLE || state_q == S_DONE || (state_q == S_LOOKUP && hit))
            state_d = accept ? S_LOOKUP : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            resp_q       <= '0;
            fence_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) addr_q <= addr_inst[31:3];
            if (state_q == S_LOOKUP) fence_pend_q <= 1'b0;
            if (fence_i && (state_q == S_MISS_REQ || state_q == S_REFILL))
                fence_pend_q <= 1'b1;
            if (state_q == S_MISS_REQ) cnt_q <= '0;
            if (state_q == S_REFILL && mem_rvalid) begin
                cnt_q <= BEAT_W'(cnt_q + 1'b1);
                if (cnt_q == req_beat) resp_q <= mem_rdata;
                // A fence seen anywhere in this refill keeps the line invalid
                if (last_beat && !fence_pend_q && !fence_i) valid_q[req_idx] <= 1'b1;
            end
            if (fence_i) valid_q <= '0;
        end
    end

    // Tag and data arrays carry no reset; validity is tracked by valid_q
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_REFILL && mem_rvalid) begin
            data_mem[req_idx][cnt_q] <= mem_rdata;
            if (last_beat) tag_mem[req_idx] <= req_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [63:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_LOOKUP) begin
            if (hit) hit_cnt_q  <= hit_cnt_q + 64'd1;
            else     miss_cnt_q <= miss_cnt_q + 64'd1;
        end
    end

    assign perf_hit  = hit_cnt_q;
    assign perf_miss = miss_cnt_q;
`else
    assign perf_hit  = 64'd0;
    assign perf_miss = 64'd0;
`endif

endmodule
